avalon_bram_burst: RTL and testbench
====================================

Name: avalon_bram_burst

Overview:
Parametrised Avalon-MM agent wrapping an on-chip block RAM with configurable data width and depth. Supports full burst reads and writes, per-byte enables and address wrap-around. Successor to the single-beat BRAM agent. Sits behind the Avalon interconnect as a memory target for masters such as the video and DMA controllers.

Parameters:
DATA_W, 32, data bus width in bits; multiple of 8, >= 8
RAM_ADD_W, 8, word-address width; memory depth = 2**RAM_ADD_W words
BURSTCOUNT_W, 4, burstcount width; legal bursts 1 .. 2**(BURSTCOUNT_W-1)
ADDR_W, 32, byte-address width of the bus
(derived) BE_W = DATA_W/8; WORD_SHIFT = log2(BE_W)

Ports:
clk  in  1  single clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
address  in  ADDR_W  byte address; word index = address >> WORD_SHIFT, modulo depth
read  in  1  read command
write  in  1  write beat
burstcount  in  BURSTCOUNT_W  beats in the burst; sampled on the first beat only
byteenable  in  BE_W  per-byte write enable, sampled on every write beat
writedata  in  DATA_W  write data
waitrequest  out  1  registered; 1 = command or beat not accepted
readdata  out  DATA_W  registered read data
readdatavalid  out  1  registered; 1 = readdata holds a valid beat

Behaviour:
- Reset (reset_n low, asynchronous): waitrequest=1, readdatavalid=0, readdata=0, state IDLE, beat counter=0. RAM contents are not cleared.
- First rising edge after release: waitrequest goes to 0.
- Acceptance: a command or beat is accepted on an edge where (read|write)=1 and waitrequest=0.
- burstcount=0 is treated as 1. Counter arithmetic uses BURSTCOUNT_W bits.
- Burst addresses increment by one word and wrap modulo 2**RAM_ADD_W. For example, word 2**RAM_ADD_W-1 is followed by word 0.
- State IDLE: waitrequest=0.
  - write accepted at edge E0: word base is written with writedata/byteenable. Base and remaining=N-1 are captured. If N>1, go to WRITE.
  - read accepted at E0: RAM read of base, then go to READ with remaining=N-1. waitrequest is registered to (N>1).
  - read and write both high: illegal. write wins; the bench flags it with an assertion.
- State WRITE: waitrequest stays 0.
  - Each edge with write=1 writes the next word and decrements remaining. At 0, go to IDLE.
  - write=0 pauses the burst; no timeout.
  - read in WRITE is ignored.
- State READ: waitrequest=1. One RAM read per edge (words base+1 .. base+N-1); read/write inputs are ignored.
  - When the last word is issued, go to IDLE and waitrequest is registered 0.
- Read latency: beat i is registered at edge Ei. readdatavalid=1 for exactly N consecutive cycles, starting the cycle after E0.
- readdata keeps its last value when readdatavalid=0.
- Back-to-back: a new command can be accepted at edge EN, in the same cycle the last beat is valid. The new burst's readdatavalid follows contiguously.
- RAM: BE_W byte lanes; lane k is written from writedata[8k+7:8k] when byteenable[k]=1.
- Read-during-write to the same word is impossible by construction, because a write is never accepted in READ.
- Reset mid-burst: the burst is aborted immediately. readdatavalid drops and waitrequest=1 while reset_n is low. Words already written are kept.

Test Plan:
1. Reset: hold reset_n=0 for 3 cycles -> waitrequest=1, readdatavalid=0, readdata=0. One edge after release -> waitrequest=0.
2. Single beat: write 0xDEADBEEF to 0x10, be=4'b1111; then read 0x10, burstcount=1 -> readdatavalid=1 for 1 cycle, starting the cycle after acceptance, readdata=0xDEADBEEF. waitrequest stays 0.
3. Byte enables: write 0x11223344 to 0x20, then 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
4. Bursts: burst write N=4 at 0x40 with data 1,2,3,4, write=0 for 2 cycles before beat 3; then burst read N=4 at 0x40 -> readdatavalid high 4 consecutive cycles with 1,2,3,4. waitrequest high for the 3 cycles after acceptance. An immediate second read of 0x40 (N=1) yields 1 in the cycle after the 4th beat.
5. Wrap and burstcount=0: burst write N=3 at byte 0x3F8 (word 254) with A,B,C -> word 0 holds C. Read at 0x000 with burstcount=0 -> exactly one beat, value C.
6. Reset mid-read: burst read N=8; assert reset_n=0 after 3 beats -> readdatavalid=0 asynchronously. After release, a read at 0x10 returns 0xDEADBEEF (contents retained).

Source files
------------

// File: rtl/avalon_bram_burst_if.sv
// rtl/avalon_bram_burst_if.sv - Avalon-MM burst bus bundle for the BRAM agent
//
// Purpose: groups the Avalon-MM command, write-data and response signals used
// between an interconnect master and the avalon_bram_burst memory target.
// Signals:
//   address       byte address (ADDR_W)
//   read, write   command / write-beat strobes
//   burstcount    beats in the burst, valid on the first beat
//   byteenable    per-byte write enables (BE_W)
//   writedata     write data (DATA_W)
//   waitrequest   target busy, command or beat not accepted
//   readdata      read data beat (DATA_W)
//   readdatavalid readdata holds a valid beat
// Modports: master drives commands, slave drives responses.

interface avalon_bram_burst_if #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BURSTCOUNT_W = 4
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0]       address;
  logic                    read;
  logic                    write;
  logic [BURSTCOUNT_W-1:0] burstcount;
  logic [BE_W-1:0]         byteenable;
  logic [DATA_W-1:0]       writedata;
  logic                    waitrequest;
  logic [DATA_W-1:0]       readdata;
  logic                    readdatavalid;

  modport master (
    output address, read, write, burstcount, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, burstcount, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_bram_burst.sv
// rtl/avalon_bram_burst.sv - Avalon-MM burst agent wrapping an on-chip block RAM
//
// Purpose: memory target behind the Avalon interconnect. Accepts single and
// burst reads/writes with per-byte enables; burst word addresses wrap modulo
// the RAM depth. Read beats come out one per cycle, one cycle after issue.
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous active-low reset (RAM contents are kept)
//   bus      avalon_bram_burst_if.slave: address/read/write/burstcount/
//            byteenable/writedata in; waitrequest/readdata/readdatavalid out

module avalon_bram_burst #(
  parameter int DATA_W       = 32,
  parameter int RAM_ADD_W    = 8,
  parameter int BURSTCOUNT_W = 4,
  parameter int ADDR_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avalon_bram_burst_if.slave    bus
);
  localparam int BE_W       = DATA_W / 8;
  localparam int WORD_SHIFT = $clog2(BE_W);
  localparam int DEPTH      = 2 ** RAM_ADD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                  state;
  logic                    waitrequest_q;
  logic                    readdatavalid_q;
  logic [DATA_W-1:0]       readdata_q;
  logic [RAM_ADD_W-1:0]    ptr;        // next word of the current burst
  logic [BURSTCOUNT_W-1:0] remaining;  // beats still to come after the current one

  logic [DATA_W-1:0]       mem [DEPTH];

  logic [RAM_ADD_W-1:0]    cmd_word;
  logic [BURSTCOUNT_W-1:0] len_m1;
  logic                    rd_issue;
  logic [RAM_ADD_W-1:0]    rd_addr;
  logic                    wr_en;
  logic [RAM_ADD_W-1:0]    wr_addr;
  logic                    unused_addr_bits;

  // Word index of the command address; upper address bits fold away (wrap).
  assign cmd_word         = bus.address[WORD_SHIFT +: RAM_ADD_W];
  assign unused_addr_bits = ^bus.address;

  // burstcount of zero behaves as a single beat.
  assign len_m1 = (bus.burstcount == '0) ? '0 : bus.burstcount - BURSTCOUNT_W'(1);

  assign bus.waitrequest   = waitrequest_q;
  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = readdatavalid_q;

  // RAM port selection. In IDLE a simultaneous read and write resolves to the
  // write. READ holds waitrequest high, so writes never collide with reads.
  always_comb begin
    rd_issue = 1'b0;
    rd_addr  = ptr;
    wr_en    = 1'b0;
    wr_addr  = ptr;
    case (state)
      IDLE: begin
        if (!waitrequest_q) begin
          if (bus.write) begin
            wr_en   = 1'b1;
            wr_addr = cmd_word;
          end else if (bus.read) begin
            rd_issue = 1'b1;
            rd_addr  = cmd_word;
          end
        end
      end
      WRITE: begin
        if (bus.write && !waitrequest_q) begin
          wr_en = 1'b1;
        end
      end
      READ: begin
        rd_issue = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Byte-lane RAM; not reset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < BE_W; k++) begin
        if (bus.byteenable[k]) begin
          mem[wr_addr][8*k +: 8] <= bus.writedata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      waitrequest_q   <= 1'b1;
      readdatavalid_q <= 1'b0;
      readdata_q      <= '0;
      ptr             <= '0;
      remaining       <= '0;
    end else begin
      readdatavalid_q <= rd_issue;
      if (rd_issue) begin
        readdata_q <= mem[rd_addr];
      end

      case (state)
        IDLE: begin
          waitrequest_q <= 1'b0;
          if (wr_en || rd_issue) begin
            ptr       <= cmd_word + RAM_ADD_W'(1);
            remaining <= len_m1;
            if (len_m1 != '0) begin
              state         <= wr_en ? WRITE : READ;
              // A multi-beat read streams its words on the following edges
              // and cannot take new commands meanwhile.
              waitrequest_q <= rd_issue;
            end
          end
        end
        WRITE: begin
          if (wr_en) begin
            ptr       <= ptr + RAM_ADD_W'(1);
            remaining <= remaining - BURSTCOUNT_W'(1);
            if (remaining == BURSTCOUNT_W'(1)) begin
              state <= IDLE;
            end
          end
        end
        READ: begin
          ptr       <= ptr + RAM_ADD_W'(1);
          remaining <= remaining - BURSTCOUNT_W'(1);
          // Dropping waitrequest with the last issue lets the next command be
          // accepted while the last beat is on the bus.
          if (remaining == BURSTCOUNT_W'(1)) begin
            state         <= IDLE;
            waitrequest_q <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          waitrequest_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_bram_burst.sv
// tb/tb_avalon_bram_burst.sv - directed self-checking bench for avalon_bram_burst

module tb_avalon_bram_burst;
  localparam int DATA_W       = 32;
  localparam int RAM_ADD_W    = 8;
  localparam int BURSTCOUNT_W = 4;
  localparam int ADDR_W       = 32;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  avalon_bram_burst_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURSTCOUNT_W(BURSTCOUNT_W)
  ) bus ();

  avalon_bram_burst #(
    .DATA_W(DATA_W), .RAM_ADD_W(RAM_ADD_W),
    .BURSTCOUNT_W(BURSTCOUNT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stimulus must never raise read and write together.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(bus.read && bus.write)) else begin
        bad++;
        $error("FAIL rw_overlap observed=1 expected=0");
      end
    end
  end

  task automatic set_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] bc, input logic [31:0] wd, input logic [3:0] be);
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = addr;
    bus.burstcount = bc;
    bus.writedata  = wd;
    bus.byteenable = be;
  endtask

  task automatic idle_bus();
    set_cmd(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 4'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    idle_bus();

    // 1. reset
    repeat (3) @(negedge clk);
    chk("rst_waitrequest", 32'(bus.waitrequest), 32'd1);
    chk("rst_rdvalid", 32'(bus.readdatavalid), 32'd0);
    chk("rst_readdata", bus.readdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_waitrequest", 32'(bus.waitrequest), 32'd0);

    // 2. single beat
    set_cmd(1'b0, 1'b1, 32'h10, 4'd1, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("single_wr_wait", 32'(bus.waitrequest), 32'd0);
    set_cmd(1'b1, 1'b0, 32'h10, 4'd1, 32'h0, 4'h0);
    @(negedge clk);
    idle_bus();
    chk("single_rd_valid", 32'(bus.readdatavalid), 32'd1);
    chk("single_rd_data", bus.readdata, 32'hDEADBEEF);
    chk("single_rd_wait", 32'(bus.waitrequest), 32'd0);
    @(negedge clk);
    chk("single_rd_valid_drop", 32'(bus.readdatavalid), 32'd0);
    chk("single_rd_data_hold", bus.readdata, 32'hDEADBEEF);

    // 3. byte enables
    set_cmd(1'b0, 1'b1, 32'h20, 4'd1, 32'h11223344, 4'hF);
    @(negedge clk);
    set_cmd(1'b0, 1'b1, 32'h20, 4'd1, 32'hAABBCCDD, 4'b0101);
    @(negedge clk);
    set_cmd(1'b1, 1'b0, 32'h20, 4'd1, 32'h0, 4'h0);
    @(negedge clk);
    idle_bus();
    chk("be_valid", 32'(bus.readdatavalid), 32'd1);
    chk("be_data", bus.readdata, 32'h11BB33DD);

    // 4. burst write with pause, burst read, back-to-back read
    set_cmd(1'b0, 1'b1, 32'h40, 4'd4, 32'd1, 4'hF);
    @(negedge clk);
    set_cmd(1'b0, 1'b1, 32'h0, 4'd0, 32'd2, 4'hF);
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    chk("bw_pause_wait", 32'(bus.waitrequest), 32'd0);
    @(negedge clk);
    set_cmd(1'b0, 1'b1, 32'h0, 4'd0, 32'd3, 4'hF);
    @(negedge clk);
    set_cmd(1'b0, 1'b1, 32'h0, 4'd0, 32'd4, 4'hF);
    @(negedge clk);
    set_cmd(1'b1, 1'b0, 32'h40, 4'd4, 32'h0, 4'h0);
    @(negedge clk);
    idle_bus();
    chk("br_b0_valid", 32'(bus.readdatavalid), 32'd1);
    chk("br_b0_data", bus.readdata, 32'd1);
    chk("br_b0_wait", 32'(bus.waitrequest), 32'd1);
    @(negedge clk);
    chk("br_b1_valid", 32'(bus.readdatavalid), 32'd1);
    chk("br_b1_data", bus.readdata, 32'd2);
    chk("br_b1_wait", 32'(bus.waitrequest), 32'd1);
    @(negedge clk);
    chk("br_b2_valid", 32'(bus.readdatavalid), 32'd1);
    chk("br_b2_data", bus.readdata, 32'd3);
    chk("br_b2_wait", 32'(bus.waitrequest), 32'd1);
    @(negedge clk);
    chk("br_b3_valid", 32'(bus.readdatavalid), 32'd1);
    chk("br_b3_data", bus.readdata, 32'd4);
    chk("br_b3_wait", 32'(bus.waitrequest), 32'd0);
    set_cmd(1'b1, 1'b0, 32'h40, 4'd1, 32'h0, 4'h0);
    @(negedge clk);
    idle_bus();
    chk("b2b_valid", 32'(bus.readdatavalid), 32'd1);
    chk("b2b_data", bus.readdata, 32'd1);
    @(negedge clk);
    chk("b2b_valid_drop", 32'(bus.readdatavalid), 32'd0);

    // 5. wrap-around and burstcount=0
    set_cmd(1'b0, 1'b1, 32'h3F8, 4'd3, 32'hA0A0A0A0, 4'hF);
    @(negedge clk);
    set_cmd(1'b0, 1'b1, 32'h0, 4'd0, 32'hB0B0B0B0, 4'hF);
    @(negedge clk);
    set_cmd(1'b0, 1'b1, 32'h0, 4'd0, 32'hC0C0C0C0, 4'hF);
    @(negedge clk);
    set_cmd(1'b1, 1'b0, 32'h000, 4'd0, 32'h0, 4'h0);
    @(negedge clk);
    idle_bus();
    chk("wrap_bc0_valid", 32'(bus.readdatavalid), 32'd1);
    chk("wrap_bc0_data", bus.readdata, 32'hC0C0C0C0);
    chk("wrap_bc0_wait", 32'(bus.waitrequest), 32'd0);
    @(negedge clk);
    chk("wrap_bc0_single", 32'(bus.readdatavalid), 32'd0);
    set_cmd(1'b1, 1'b0, 32'h3FC, 4'd1, 32'h0, 4'h0);
    @(negedge clk);
    idle_bus();
    chk("wrap_w255_data", bus.readdata, 32'hB0B0B0B0);

    // 6. reset in the middle of a read burst
    @(negedge clk);
    set_cmd(1'b1, 1'b0, 32'h40, 4'd8, 32'h0, 4'h0);
    @(negedge clk);
    idle_bus();
    chk("mid_b0_data", bus.readdata, 32'd1);
    @(negedge clk);
    chk("mid_b1_data", bus.readdata, 32'd2);
    @(negedge clk);
    chk("mid_b2_valid", 32'(bus.readdatavalid), 32'd1);
    chk("mid_b2_data", bus.readdata, 32'd3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.readdatavalid), 32'd0);
    chk("mid_rst_wait", 32'(bus.waitrequest), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_hold_valid", 32'(bus.readdatavalid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_post_wait", 32'(bus.waitrequest), 32'd0);
    chk("mid_post_valid", 32'(bus.readdatavalid), 32'd0);
    set_cmd(1'b1, 1'b0, 32'h10, 4'd1, 32'h0, 4'h0);
    @(negedge clk);
    idle_bus();
    chk("retain_valid", 32'(bus.readdatavalid), 32'd1);
    chk("retain_data", bus.readdata, 32'hDEADBEEF);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
